// File: rtl/ieee_adder_rr_arbiter_if.sv
// Request/response bundle between the FPU clients and the shared-adder arbiter.
// Slice i of each vector belongs to requester i.
interface ieee_adder_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [NUM_REQ*WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/ieee_adder_rr_arbiter.sv
// Round-robin sharing of one combinational IEEE-754 add/sub unit between NUM_REQ
// requesters; one operand stage, per-requester response registers.
module ieee_adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    ieee_adder_rr_arbiter_if.slave req_if,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_sub,
    input  logic [WIDTH-1:0]       add_result,
    output logic [NUM_REQ-1:0]     busy
);
    localparam int unsigned NREQ_U = NUM_REQ;

    logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v;
    logic [NUM_REQ-1:0][WIDTH-1:0] resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0]            eligible, grant, resp_hs;
    logic [NUM_REQ-1:0]            busy_q, busy_d, resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d, s_tag_q, gnt_idx, cand;
    logic                          s_v_q, gnt_found, accept;
    logic [WIDTH-1:0]              add_a_q, add_b_q;
    logic                          add_sub_q;

    assign a_v = req_if.req_a;
    assign b_v = req_if.req_b;

    // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        eligible  = req_if.req_valid & ~busy_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NREQ_U);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        accept = gnt_found && !reset;
        grant  = '0;
        if (accept) grant[gnt_idx] = 1'b1;
        ptr_d = accept ? IDX_W'((32'(gnt_idx) + 32'd1) % NREQ_U) : ptr_q;
    end

    always_comb begin
        resp_hs      = resp_valid_q & req_if.resp_ready;
        busy_d       = busy_q & ~resp_hs;
        resp_valid_d = resp_valid_q & ~resp_hs;
        resp_data_d  = resp_data_q;
        if (accept) busy_d[gnt_idx] = 1'b1;
        // The stage tag always points at a busy, non-valid slot, so no collision.
        if (s_v_q) begin
            resp_valid_d[s_tag_q] = 1'b1;
            resp_data_d[s_tag_q]  = add_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            s_v_q        <= 1'b0;
            s_tag_q      <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_sub_q    <= 1'b0;
            busy_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            s_v_q        <= accept;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            if (accept) begin
                s_tag_q   <= gnt_idx;
                add_a_q   <= a_v[gnt_idx];
                add_b_q   <= b_v[gnt_idx];
                add_sub_q <= req_if.req_sub[gnt_idx];
            end
        end
    end

    assign req_if.req_ready  = grant;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign add_a             = add_a_q;
    assign add_b             = add_b_q;
    assign add_sub           = add_sub_q;
    assign busy              = busy_q;
endmodule

// File: doc/ieee_adder_rr_arbiter.md
Name: ieee_adder_rr_arbiter

Overview:
Shares one combinational IEEE-754 single-precision add/sub datapath between NUM_REQ independent requesters. Arbitration is round-robin. The winner's operands and operation are registered and driven into the shared adder. The adder result is captured into a per-requester response register, which is returned over a valid/ready handshake. It sits between the FPU client ports and the single adder instance, so that only one adder is built per cluster.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width; equals `TOTALBITS
IDX_W, 2, width of requester index; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero
req_a  input  NUM_REQ*WIDTH  operand A; slice i belongs to requester i
req_b  input  NUM_REQ*WIDTH  operand B
req_sub  input  NUM_REQ  1 = A-B, 0 = A+B
resp_valid  output  NUM_REQ  per-requester result valid
resp_ready  input  NUM_REQ  per-requester result accept
resp_data  output  NUM_REQ*WIDTH  result; slice i belongs to requester i
add_a  output  WIDTH  registered operand A to the shared adder
add_b  output  WIDTH  registered operand B to the shared adder
add_sub  output  1  registered add_sub_bit to the shared adder
add_result  input  WIDTH  combinational adder output, computed from add_a/add_b/add_sub
busy  output  NUM_REQ  per-requester slot occupied (in flight or result pending)

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high.
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_data = 0, busy = 0.
  - add_a = 0, add_b = 0, add_sub = 0.
  - Round-robin pointer ptr = 0; stage valid s_v = 0; stage tag s_tag = 0.
- Eligibility: requester i is eligible when req_valid[i] && !busy[i]. busy is registered, so a slot freed in cycle t is eligible from t+1.
- Grant selection (combinational):
  - Pick the first eligible index, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[i] = 1 only for that index; req_ready is all-zero when no index is eligible.
  - req_ready depends only on req_valid and registered state; it must never depend on resp_ready.
- Accept in cycle t (req_valid[g] && req_ready[g]):
  - At the edge ending t: add_a <= req_a[g], add_b <= req_b[g], add_sub <= req_sub[g], s_v <= 1, s_tag <= g, busy[g] <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - With no accept: s_v <= 0; ptr and add_* hold their values.
- Execute in cycle t+1: if s_v, then resp_data[s_tag] <= add_result and resp_valid[s_tag] <= 1 at the edge ending t+1.
- Latency: the result is visible from cycle t+2.
- Throughput: one accept per cycle across all requesters; at most one outstanding operation per requester.
- Response handshake: when resp_valid[i] && resp_ready[i] in cycle u:
  - At the edge ending u: resp_valid[i] <= 0 and busy[i] <= 0.
  - resp_data[i] holds its value until overwritten.
  - resp_valid[i] and resp_data[i] stay stable while resp_ready[i] = 0, for any number of cycles.
- Collision-free by construction: a write to slot s_tag can never hit a slot whose resp_valid is already 1, because busy blocked any new grant to it.
- Simultaneous events:
  - Response handshake on i plus a new request from i in the same cycle: not granted that cycle (busy is still 1); eligible next cycle.
  - Accept for j plus result write for k in the same cycle: both happen; j != k, or j == k is impossible.
- Arithmetic: the block does no arithmetic on operands; add_result passes through unmodified (signed-zero, denormal and overflow behaviour belong to the adder).
- Reset mid-operation: the in-flight op is discarded, pending responses are dropped, and all registers return to their reset values at the next edge. There is no spurious resp_valid after reset.
- Unused index values ≥ NUM_REQ are never produced.

Test Plan:
- Single op: requester 0, A=0x3F800000, B=0x40000000, sub=0, accepted in cycle 1 -> add_a/add_b driven in cycle 2; resp_valid[0]=1 with resp_data[0]=0x40400000 in cycle 3; busy[0] clears after the resp handshake.
- Subtract: requester 2, A=0x40400000, B=0x3F800000, sub=1 -> resp_data[2]=0x40000000 two cycles after accept.
- All four valid in the same cycle with ptr=0 -> grants go 0,1,2,3 on consecutive cycles; results arrive on consecutive cycles; ptr ends at 0.
- Fairness and wrap: after a grant to requester 3, requesters 0 and 3 both request (3's slot freed) -> requester 0 is granted first, then requester 3.
- Backpressure: resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_data[1] stay stable; req_ready[1] stays 0 despite req_valid[1]=1; other requesters proceed. Raising resp_ready[1] frees the slot, and requester 1 is granted the following cycle.
- Reset mid-op: assert reset the cycle after an accept -> the next cycle shows resp_valid=0, busy=0, req_ready=0; no result appears after reset deasserts.
